// File: rtl/frank_pkg.sv
// Shared definitions for the FRANK6000 sequencing blocks: the FSM state
// encoding used by the PC sequencer and the default reset vector.
package frank_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_RET_WAIT = 2'd1,
    ST_FAULT    = 2'd2
  } pc_state_e;

  localparam int          DEFAULT_ADDR_WIDTH   = 4;
  localparam int          DEFAULT_DATA_WIDTH   = 16;
  localparam logic [15:0] DEFAULT_RESET_VECTOR = 16'h0000;

endpackage

// File: rtl/pc_depth_counter.sv
// Up/down saturating occupancy counter with full/empty flags. Counts
// 0..2**ADDR_WIDTH. Simultaneous inc and dec cancel out. Shared with the
// data-stack controller.
module pc_depth_counter #(
  parameter int ADDR_WIDTH = 4
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_inc,
  input  logic                i_dec,
  output logic [ADDR_WIDTH:0] o_count,
  output logic                o_full,
  output logic                o_empty
);

  localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};

  logic [ADDR_WIDTH:0] count_q;

  // Occupancy register: moves by one and never goes past either bound.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      count_q <= '0;
    end else if (i_inc && !i_dec && (count_q != DEPTH)) begin
      count_q <= count_q + ONE;
    end else if (i_dec && !i_inc && (count_q != '0)) begin
      count_q <= count_q - ONE;
    end
  end

  assign o_count = count_q;
  assign o_full  = (count_q == DEPTH);
  assign o_empty = (count_q == '0);

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer for the FRANK6000 core. Owns the PC and picks
// increment / jump / call / return each cycle, strobing the external
// Instruction_Stack and tracking its depth.
// Build option PC_SEQ_GUARD_EN: a call when full or a return when empty
// moves the sequencer into a sticky FAULT state instead of corrupting the
// stack. Without it, such requests still strobe and the depth saturates.
module pc_sequencer
  import frank_pkg::*;
#(
  parameter int                    ADDR_WIDTH   = DEFAULT_ADDR_WIDTH,
  parameter int                    DATA_WIDTH   = DEFAULT_DATA_WIDTH,
  parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = DATA_WIDTH'(DEFAULT_RESET_VECTOR)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_en,
  input  logic                  i_jmp,
  input  logic                  i_call,
  input  logic                  i_ret,
  input  logic [DATA_WIDTH-1:0] i_target,
  input  logic [DATA_WIDTH-1:0] i_stk_data,
  output logic [DATA_WIDTH-1:0] o_pc,
  output logic                  o_stk_call,
  output logic                  o_stk_rtrn,
  output logic [DATA_WIDTH-1:0] o_stk_pc,
  output logic [ADDR_WIDTH:0]   o_depth,
  output logic                  o_stall,
  output logic                  o_fault
);

  localparam logic [DATA_WIDTH-1:0] PC_ONE = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

  pc_state_e             state_q, state_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic                  stk_call, stk_rtrn;
  logic                  cnt_inc, cnt_dec;
  logic                  cnt_full, cnt_empty;
  logic                  call_blocked, ret_blocked;

`ifdef PC_SEQ_GUARD_EN
  assign call_blocked = cnt_full;
  assign ret_blocked  = cnt_empty;
`else
  assign call_blocked = 1'b0;
  assign ret_blocked  = 1'b0;
`endif

  pc_depth_counter #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_depth (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_inc  (cnt_inc),
    .i_dec  (cnt_dec),
    .o_count(o_depth),
    .o_full (cnt_full),
    .o_empty(cnt_empty)
  );

  // PC and FSM state registers; reset forces the PC back to the vector.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_VECTOR;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // Next PC, next state and stack strobes, ret > call > jmp > increment.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    stk_call = 1'b0;
    stk_rtrn = 1'b0;
    cnt_inc  = 1'b0;
    cnt_dec  = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (i_en) begin
          if (i_ret) begin
            if (ret_blocked) begin
              state_d = ST_FAULT;
            end else begin
              stk_rtrn = 1'b1;
              cnt_dec  = !cnt_empty;
              state_d  = ST_RET_WAIT;
            end
          end else if (i_call) begin
            if (call_blocked) begin
              state_d = ST_FAULT;
            end else begin
              stk_call = 1'b1;
              cnt_inc  = !cnt_full;
              pc_d     = i_target;
            end
          end else if (i_jmp) begin
            pc_d = i_target;
          end else begin
            pc_d = pc_q + PC_ONE;
          end
        end
      end
      ST_RET_WAIT: begin
        pc_d    = i_stk_data;
        state_d = ST_RUN;
      end
      ST_FAULT: begin
        state_d = ST_FAULT;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  assign o_pc       = pc_q;
  assign o_stk_pc   = pc_q;
  assign o_stk_call = stk_call;
  assign o_stk_rtrn = stk_rtrn;
  assign o_stall    = (state_q == ST_RET_WAIT);

`ifdef PC_SEQ_GUARD_EN
  assign o_fault = (state_q == ST_FAULT);
`else
  assign o_fault = 1'b0;
`endif

endmodule
